// File: rtl/instr_loader.sv
// Boot-time loader: turns a length-prefixed byte stream into 24-bit instruction-memory writes
// and releases the CPU once the image is in. Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module instr_loader #(
    parameter int ADDR_W    = 24,
    parameter int BASE_ADDR = 10,
    parameter int ADDR_STEP = 3,
    parameter int MAX_WORDS = 1024
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              ByteValid,
    input  logic [7:0]        ByteData,
    output logic              ByteReady,
    output logic              ImemWrite,
    output logic [ADDR_W-1:0] ImemAddr,
    output logic [23:0]       ImemData,
    output logic              Busy,
    output logic              CpuRun,
    output logic              Error,
    output logic [15:0]       WordsLoaded
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LEN_HI = 4'd1;
    localparam logic [3:0] ST_LEN_LO = 4'd2;
    localparam logic [3:0] ST_BYTE2  = 4'd3;
    localparam logic [3:0] ST_BYTE1  = 4'd4;
    localparam logic [3:0] ST_BYTE0  = 4'd5;
    localparam logic [3:0] ST_WRITE  = 4'd6;
    localparam logic [3:0] ST_DONE   = 4'd7;
    localparam logic [3:0] ST_ERR    = 4'd8;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] ST_CHK    = 4'd9;
    localparam logic [3:0] ST_FINISH = ST_CHK;
`else
    localparam logic [3:0] ST_FINISH = ST_DONE;
`endif

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);
    localparam logic [16:0]       MAX_W  = 17'(MAX_WORDS);

    logic [3:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       word_q, word_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [23:0]       imem_data_q, imem_data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    logic [15:0]       len_in;
    logic              xfer;

    always_comb begin
        ByteReady = 1'b0;
        case (state_q)
            ST_LEN_HI, ST_LEN_LO, ST_BYTE2, ST_BYTE1, ST_BYTE0: ByteReady = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: ByteReady = 1'b1;
`endif
            default: ByteReady = 1'b0;
        endcase
    end

    assign xfer   = ByteValid & ByteReady;
    assign len_in = {len_q[15:8], ByteData};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        waddr_d     = waddr_q;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_LEN_HI;
                    cnt_d   = '0;
                    waddr_d = BASE_A;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = ByteData;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_in;
                    if (len_in == 16'd0)             state_d = ST_FINISH;
                    else if ({1'b0, len_in} > MAX_W) state_d = ST_ERR;
                    else                             state_d = ST_BYTE2;
                end
            end
            ST_BYTE2: begin
                if (xfer) begin
                    word_d[15:8] = ByteData;
`ifdef LOADER_CHECKSUM_EN
                    csum_d       = csum_q ^ ByteData;
`endif
                    state_d      = ST_BYTE1;
                end
            end
            ST_BYTE1: begin
                if (xfer) begin
                    word_d[7:0] = ByteData;
`ifdef LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ ByteData;
`endif
                    state_d     = ST_BYTE0;
                end
            end
            ST_BYTE0: begin
                // Address/data land in their output flops here so they are stable throughout WRITE.
                if (xfer) begin
                    imem_data_d = {word_q, ByteData};
                    imem_addr_d = waddr_q;
`ifdef LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ ByteData;
`endif
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_d   = cnt_q + 16'd1;
                waddr_d = waddr_q + STEP_A;
                state_d = (cnt_q == len_q - 16'd1) ? ST_FINISH : ST_BYTE2;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer) state_d = (ByteData == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: state_d = state_q;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            waddr_q     <= '0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            waddr_q     <= waddr_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        Busy = 1'b0;
        case (state_q)
            ST_LEN_HI, ST_LEN_LO, ST_BYTE2, ST_BYTE1, ST_BYTE0, ST_WRITE: Busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: Busy = 1'b1;
`endif
            default: Busy = 1'b0;
        endcase
    end

    assign ImemWrite   = (state_q == ST_WRITE);
    assign ImemAddr    = imem_addr_q;
    assign ImemData    = imem_data_q;
    assign CpuRun      = (state_q == ST_DONE);
    assign Error       = (state_q == ST_ERR);
    assign WordsLoaded = cnt_q;

endmodule
